instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-002 SHALL have in_valid in 1 (request present), in_ready out 1 (request accepted when both high), in_op in 4 (opcode), in_func in 3 (function code).
REQ-003 SHALL have in_rd, in_rs, in_rt in 3 each (register numbers) and in_imm in 16 (signed or unsigned immediate/offset value).
REQ-004 SHALL have base_addr in 8 (load start address), restart in 1 (reset write pointer to base_addr), and wr_en out 1, wr_addr out 8, wr_data out 16 (instruction-memory write port).
REQ-005 SHALL have full out 1 (memory exhausted), count out 9 (words written since restart), and err out 1 (one-cycle illegal-request pulse).

Function
REQ-006 SHALL encode each request into one 16-bit word, op always in [15:12].
REQ-007 R-type (op 0): {op, rd[11:9], rs[8:6], rt[5:3], func[2:0]}.
REQ-008 ANDI, ADDI, LW, SW, BEQ, BNE, FOR: {op, rt[11:9], rs[8:6], imm[5:0]}; FOR ignores rt and places rs in [8:6].
REQ-009 Any other op (jump class, including CALL as func 3'b001): {op, imm[8:0] at [11:3], func[2:0]}.
REQ-010 SHALL run FSM IDLE -> ENC -> WRITE -> IDLE; in_ready high only in IDLE with full low.
REQ-011 On acceptance, SHALL register all inputs and go to ENC; in ENC SHALL form the word; in WRITE SHALL assert wr_en for exactly one cycle with wr_addr = pointer, wr_data = word.
REQ-012 Latency: acceptance at edge N -> wr_en high in the cycle after edge N+1; sustained throughput one word per 3 cycles.
REQ-013 After each write SHALL increment pointer modulo 256 and count by 1.
REQ-014 SHALL set full when count reaches 256; while full, in_ready low, no writes, pointer held.
REQ-015 restart in IDLE SHALL load pointer = base_addr, clear count and full in the next cycle; restart in ENC or WRITE SHALL be held pending and applied on return to IDLE, never dropped or aborting the write.
REQ-016 restart coincident with in_valid in IDLE SHALL take priority: in_ready low that cycle, request not accepted.
REQ-017 Pointer wrap 255 -> 0 SHALL be silent; only count governs full.

Reset
REQ-018 reset SHALL force FSM IDLE, pointer 0, count 0, full 0, wr_en 0, wr_addr 0, wr_data 0, err 0, pending restart cleared, in_ready 1 in the next cycle.
REQ-019 reset during ENC or WRITE SHALL abandon the request; no wr_en is issued for it.

Configuration
REQ-020 With macro INSTR_ENCODER_RANGE_CHECK_EN defined: in ENC, immediate out of range (ADDI/LW/SW/BEQ/BNE/FOR: signed outside -32..31; ANDI: unsigned > 63; jump class: signed outside -256..255) or nonzero func with op in I-class SHALL pulse err for one cycle, skip WRITE, return to IDLE, leaving pointer and count unchanged.
REQ-021 Without the macro: immediates SHALL be truncated to field width, err tied 0, every accepted request written.

Structure
REQ-022 Opcode constants (R, ANDI, ADDI, LW, SW, BEQ, BNE, FOR), the CALL func code, field bit positions and FSM state encodings SHALL reside in the shared opcodes package, one source with the control decoder.
REQ-023 Word formation SHALL be a combinational sub-module instr_pack (op, func, regs, imm -> 16-bit word, range_ok); FSM, pointer and counters in instr_encoder.

Verification
REQ-024 reset, base_addr 8'h10, restart, R-type rd 3 rs 1 rt 2 func 5 -> one wr_en, wr_addr 8'h10, wr_data {0,3'd3,3'd1,3'd2,3'd5}, count 1.
REQ-025 ADDI rt 4 rs 2 imm -1 -> wr_data {ADDI,3'd4,3'd2,6'h3F}; next LW written at 8'h11, 3 cycles after the first acceptance.
REQ-026 jump-class op func 3'b001 imm 9'h1FF -> wr_data {op,9'h1FF,3'b001}.
REQ-027 base_addr 8'hFF, restart, 256 back-to-back requests -> second write at addr 0, full rises after the 256th write, in_ready low, 257th request never accepted.
REQ-028 restart asserted during WRITE -> current write completes, next request lands at base_addr with count 1; reset asserted in ENC -> no wr_en.
REQ-029 INSTR_ENCODER_RANGE_CHECK_EN on, ADDI imm 40 -> err one cycle, no wr_en, count unchanged; macro off, same request -> wr_data imm field 6'h28.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared definitions for the instruction encoder: field widths, opcode
// constants, the CALL function code, instruction-word field positions and
// the control FSM state encoding. The RTL and the testbench both use this
// package, so the encodings are defined in one place only.
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

    localparam int OP_W   = 4;
    localparam int FUNC_W = 3;
    localparam int REG_W  = 3;
    localparam int IMM_W  = 16;
    localparam int WORD_W = 16;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 9;

    // Opcodes. Every value not listed here is a jump-class opcode.
    localparam logic [OP_W-1:0] OP_R    = 4'd0;
    localparam logic [OP_W-1:0] OP_ANDI = 4'd1;
    localparam logic [OP_W-1:0] OP_ADDI = 4'd2;
    localparam logic [OP_W-1:0] OP_LW   = 4'd3;
    localparam logic [OP_W-1:0] OP_SW   = 4'd4;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'd5;
    localparam logic [OP_W-1:0] OP_BNE  = 4'd6;
    localparam logic [OP_W-1:0] OP_FOR  = 4'd7;
    localparam logic [OP_W-1:0] OP_JMP  = 4'd8;

    // A jump-class opcode with this function code is a CALL.
    localparam logic [FUNC_W-1:0] FUNC_CALL = 3'b001;

    // Instruction-word field positions (LSB of each field).
    localparam int OP_LSB   = 12;  // op in [15:12]
    localparam int F1_LSB   = 9;   // rd (R-type) / rt (I-type)
    localparam int F2_LSB   = 6;   // rs
    localparam int F3_LSB   = 3;   // rt (R-type)
    localparam int IMM6_W   = 6;   // I-type immediate in [5:0]
    localparam int JIMM_LSB = 3;   // jump immediate in [11:3]
    localparam int JIMM_W   = 9;

    localparam logic [CNT_W-1:0] CNT_FULL = 9'd256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENC   = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
// Request bus into the instruction encoder: valid/ready handshake plus the
// decoded instruction fields.
//   in_valid / in_ready : request handshake, accepted when both are high
//   in_op, in_func      : opcode and function code
//   in_rd, in_rs, in_rt : register numbers
//   in_imm              : immediate / offset (signed or unsigned)
// master drives a request, slave (the encoder) accepts it.
// -----------------------------------------------------------------------------
interface instr_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [2:0]  in_func;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs;
    logic [2:0]  in_rt;
    logic [15:0] in_imm;

    modport master (
        output in_valid, in_op, in_func, in_rd, in_rs, in_rt, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_func, in_rd, in_rs, in_rt, in_imm,
        output in_ready
    );

endinterface

// File: rtl/instr_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Combinational instruction-word formatter.
//   op, func, rd, rs, rt, imm : captured request fields
//   word                      : 16-bit encoded instruction
//   range_ok                  : immediate fits its field and func is legal
// Immediates are truncated to their field width in word; range_ok reports
// whether that truncation lost information.
// -----------------------------------------------------------------------------
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [FUNC_W-1:0] func,
    input  logic [REG_W-1:0]  rd,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    input  logic [IMM_W-1:0]  imm,
    output logic [WORD_W-1:0] word,
    output logic              range_ok
);

    logic simm6_ok;   // -32..31
    logic uimm6_ok;   // 0..63
    logic simm9_ok;   // -256..255
    logic func_zero;

    // A signed value fits in N bits when every bit from N-1 upward equals
    // the sign bit.
    assign simm6_ok  = (imm[IMM_W-1:IMM6_W-1] == {(IMM_W-IMM6_W+1){imm[IMM_W-1]}});
    assign uimm6_ok  = (imm[IMM_W-1:IMM6_W] == '0);
    assign simm9_ok  = (imm[IMM_W-1:JIMM_W-1] == {(IMM_W-JIMM_W+1){imm[IMM_W-1]}});
    assign func_zero = (func == '0);

    // NOTE: every output gets a default before the case so no path through
    // the block leaves a value unassigned, which would infer a latch.
    always_comb begin
        word     = '0;
        range_ok = 1'b1;
        word[WORD_W-1:OP_LSB] = op;
        case (op)
            OP_R: begin
                word[F1_LSB +: REG_W]  = rd;
                word[F2_LSB +: REG_W]  = rs;
                word[F3_LSB +: REG_W]  = rt;
                word[0 +: FUNC_W]      = func;
            end
            OP_ANDI: begin
                word[F1_LSB +: REG_W]  = rt;
                word[F2_LSB +: REG_W]  = rs;
                word[0 +: IMM6_W]      = imm[IMM6_W-1:0];
                range_ok               = uimm6_ok && func_zero;
            end
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: begin
                word[F1_LSB +: REG_W]  = rt;
                word[F2_LSB +: REG_W]  = rs;
                word[0 +: IMM6_W]      = imm[IMM6_W-1:0];
                range_ok               = simm6_ok && func_zero;
            end
            OP_FOR: begin
                // FOR has no rt; its slot stays zero.
                word[F2_LSB +: REG_W]  = rs;
                word[0 +: IMM6_W]      = imm[IMM6_W-1:0];
                range_ok               = simm6_ok && func_zero;
            end
            default: begin
                // Jump class, CALL included (func = FUNC_CALL).
                word[JIMM_LSB +: JIMM_W] = imm[JIMM_W-1:0];
                word[0 +: FUNC_W]        = func;
                range_ok                 = simm9_ok;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Accepts instruction requests, encodes each into a 16-bit word and writes
// it to consecutive instruction-memory addresses starting at base_addr.
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   req           : request bus (instr_encoder_if.slave)
//   base_addr     : load start address, taken on restart
//   restart       : rewind write pointer to base_addr, clear count/full
//   wr_en/addr/data : one-cycle instruction-memory write
//   full          : 256 words written since restart; requests blocked
//   count         : words written since restart
//   err           : one-cycle pulse for a rejected request
// Optional feature macro: INSTR_ENCODER_RANGE_CHECK_EN -- when defined,
// requests with out-of-range immediates or a nonzero func on an I-class op
// are rejected with an err pulse instead of being written truncated.
// Control: IDLE (accept) -> ENC (form word) -> WRITE (wr_en) -> IDLE.
// -----------------------------------------------------------------------------
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    instr_encoder_if.slave    req,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              restart,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              err
);

    state_e              state_q,   state_d;
    logic [OP_W-1:0]     op_q,      op_d;
    logic [FUNC_W-1:0]   func_q,    func_d;
    logic [REG_W-1:0]    rd_q,      rd_d;
    logic [REG_W-1:0]    rs_q,      rs_d;
    logic [REG_W-1:0]    rt_q,      rt_d;
    logic [IMM_W-1:0]    imm_q,     imm_d;
    logic [ADDR_W-1:0]   ptr_q,     ptr_d;
    logic [CNT_W-1:0]    count_q,   count_d;
    logic                full_q,    full_d;
    logic                pend_q,    pend_d;
    logic                wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]   wr_data_q, wr_data_d;
    logic                err_q,     err_d;

    logic [WORD_W-1:0]   word;
    logic                range_ok;
    logic                reject;
    logic                do_restart;
    logic                ready;

    instr_pack u_pack (
        .op       (op_q),
        .func     (func_q),
        .rd       (rd_q),
        .rs       (rs_q),
        .rt       (rt_q),
        .imm      (imm_q),
        .word     (word),
        .range_ok (range_ok)
    );

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    assign reject = !range_ok;
`else
    logic unused_range_ok;
    assign unused_range_ok = range_ok;
    assign reject          = 1'b0;
`endif

    // A restart seen during ENC/WRITE is remembered in pend_q and applied
    // in IDLE; either form blocks acceptance that cycle.
    assign do_restart   = restart || pend_q;
    assign ready        = (state_q == ST_IDLE) && !full_q && !do_restart;
    assign req.in_ready = ready;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        func_d    = func_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        imm_d     = imm_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        full_d    = full_q;
        pend_d    = pend_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (do_restart) begin
                    ptr_d   = base_addr;
                    count_d = '0;
                    full_d  = 1'b0;
                    pend_d  = 1'b0;
                end else if (req.in_valid && ready) begin
                    op_d    = req.in_op;
                    func_d  = req.in_func;
                    rd_d    = req.in_rd;
                    rs_d    = req.in_rs;
                    rt_d    = req.in_rt;
                    imm_d   = req.in_imm;
                    state_d = ST_ENC;
                end
            end
            ST_ENC: begin
                pend_d = pend_q || restart;
                if (reject) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = word;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                pend_d  = pend_q || restart;
                // Pointer wraps silently; only the count decides full.
                ptr_d   = ptr_q + 1'b1;
                count_d = count_q + 1'b1;
                full_d  = ((count_q + 1'b1) == CNT_FULL);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            func_q    <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            imm_q     <= '0;
            ptr_q     <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            pend_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            func_q    <= func_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            imm_q     <= imm_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            pend_q    <= pend_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign full    = full_q;
    assign count   = count_q;
    assign err     = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Self-checking bench for instr_encoder. Expected writes (address, word,
// acceptance cycle) are queued when a request is accepted and compared by a
// monitor whenever wr_en is seen. Encodings come from a hand-filled vector
// table; multi-cycle corner cases are written out as short sequences.
// -----------------------------------------------------------------------------
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        restart   = 1'b0;
    logic [7:0]  base_addr = 8'h00;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        full;
    logic [8:0]  count;
    logic        err;

    instr_encoder_if bus ();

    instr_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .req       (bus),
        .base_addr (base_addr),
        .restart   (restart),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .full      (full),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  func;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [15:0] imm;
        logic [15:0] word;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          acc;
    } exp_t;

    vec_t       vecs [11];
    exp_t       sb [$];
    exp_t       mon_e;
    int         checks  = 0;
    int         errors  = 0;
    int         cyc     = 0;
    int         wr_seen = 0;
    int         err_hi  = 0;
    logic [7:0] exp_ptr = 8'h00;
    int         exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (err) err_hi++;
        if (wr_en) begin
            wr_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", wr_addr, wr_data);
            end else begin
                mon_e = sb.pop_front();
                check("wr_addr", {24'd0, wr_addr}, {24'd0, mon_e.addr});
                check("wr_data", {16'd0, wr_data}, {16'd0, mon_e.data});
                check("wr_latency", cyc, mon_e.acc + 1);
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [2:0] func, input logic [2:0] rd,
                        input logic [2:0] rs, input logic [2:0] rt, input logic [15:0] imm,
                        input logic [15:0] word, input bit exp_wr, output int acc);
        int g = 0;
        acc          = -1;
        bus.in_op    = op;
        bus.in_func  = func;
        bus.in_rd    = rd;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_imm   = imm;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!bus.in_ready) begin
            check("send_timeout", {31'd0, bus.in_ready}, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc          = cyc;
        bus.in_valid = 1'b0;
        if (exp_wr) begin
            sb.push_back('{exp_ptr, word, acc});
            exp_ptr++;
            exp_cnt++;
        end
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic pulse_restart(input logic [7:0] b);
        @(negedge clk);
        base_addr = b;
        restart   = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        exp_ptr = b;
        exp_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev;
        int g;
        int ws;
        int eh;
        int rh;
        logic [7:0] b;

        //          op       func  rd    rs    rt    imm       word
        vecs[0]  = '{OP_R,    3'd5, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h0655};
        vecs[1]  = '{OP_ADDI, 3'd0, 3'd0, 3'd2, 3'd4, 16'hFFFF, 16'h28BF};
        vecs[2]  = '{OP_LW,   3'd0, 3'd0, 3'd5, 3'd1, 16'h0007, 16'h3347};
        vecs[3]  = '{OP_SW,   3'd0, 3'd0, 3'd0, 3'd7, 16'hFFE0, 16'h4E20};
        vecs[4]  = '{OP_BEQ,  3'd0, 3'd0, 3'd3, 3'd2, 16'h001F, 16'h54DF};
        vecs[5]  = '{OP_BNE,  3'd0, 3'd0, 3'd7, 3'd0, 16'h0000, 16'h61C0};
        vecs[6]  = '{OP_FOR,  3'd0, 3'd0, 3'd6, 3'd5, 16'h0003, 16'h7183};
        vecs[7]  = '{OP_ANDI, 3'd0, 3'd0, 3'd4, 3'd3, 16'h003F, 16'h173F};
        vecs[8]  = '{OP_JMP,  FUNC_CALL, 3'd0, 3'd0, 3'd0, 16'hFFFF, 16'h8FF9};
        vecs[9]  = '{4'd15,   3'd3, 3'd0, 3'd0, 3'd0, 16'h0064, 16'hF323};
        vecs[10] = '{OP_R,    3'd7, 3'd7, 3'd7, 3'd7, 16'h0000, 16'h0FFF};

        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_func  = '0;
        bus.in_rd    = '0;
        bus.in_rs    = '0;
        bus.in_rt    = '0;
        bus.in_imm   = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_wr_en",    {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr",  {24'd0, wr_addr}, 32'd0);
        check("rst_wr_data",  {16'd0, wr_data}, 32'd0);
        check("rst_count",    {23'd0, count}, 32'd0);
        check("rst_full",     {31'd0, full}, 32'd0);
        check("rst_err",      {31'd0, err}, 32'd0);

        // Restart coincident with a valid request wins; request is dropped.
        base_addr    = 8'h10;
        restart      = 1'b1;
        bus.in_op    = OP_R;
        bus.in_valid = 1'b1;
        #1 check("ready_during_restart", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        restart      = 1'b0;
        bus.in_valid = 1'b0;
        exp_ptr      = 8'h10;
        exp_cnt      = 0;
        @(negedge clk);
        check("ready_after_restart", {31'd0, bus.in_ready}, 32'd1);

        // First R-type alone, then the rest of the table back-to-back.
        send(vecs[0].op, vecs[0].func, vecs[0].rd, vecs[0].rs, vecs[0].rt, vecs[0].imm, vecs[0].word, 1'b1, acc);
        drain();
        check("count_first", {23'd0, count}, 32'd1);
        prev = -1;
        for (int i = 1; i < 11; i++) begin
            send(vecs[i].op, vecs[i].func, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].imm, vecs[i].word, 1'b1, acc);
            if (i > 1) check("throughput", acc - prev, 3);
            prev = acc;
        end
        drain();
        check("count_table", {23'd0, count}, exp_cnt);

        // Restart during WRITE: current write completes, next lands at base.
        base_addr = 8'h40;
        send(OP_ADDI, 3'd0, 3'd0, 3'd3, 3'd5, 16'h0001, 16'h2AC1, 1'b1, acc);
        g = 0;
        while (!wr_en && g < 10) begin
            @(negedge clk);
            g++;
        end
        check("write_before_restart", {31'd0, wr_en}, 32'd1);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        exp_ptr = 8'h40;
        exp_cnt = 0;
        check("ready_while_pending", {31'd0, bus.in_ready}, 32'd0);
        send(OP_LW, 3'd0, 3'd0, 3'd1, 3'd2, 16'h0005, 16'h3445, 1'b1, acc);
        drain();
        check("count_after_restart", {23'd0, count}, 32'd1);

        // Reset while the request sits in ENC: no write may follow.
        ws = wr_seen;
        send(OP_R, 3'd0, 3'd1, 3'd1, 3'd1, 16'h0000, 16'h0000, 1'b0, acc);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_ptr = 8'h00;
        exp_cnt = 0;
        repeat (6) @(negedge clk);
        check("no_write_after_reset", wr_seen, ws);
        check("count_after_reset", {23'd0, count}, 32'd0);
        check("ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

        // Immediate range handling.
        eh = err_hi;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        send(OP_ADDI, 3'd0, 3'd0, 3'd1, 3'd1, 16'd40, 16'h0000, 1'b0, acc);
        repeat (6) @(negedge clk);
        check("err_addi_40", err_hi - eh, 1);
        check("count_after_err", {23'd0, count}, exp_cnt);
        send(OP_ANDI, 3'd0, 3'd0, 3'd1, 3'd1, 16'd64, 16'h0000, 1'b0, acc);
        repeat (6) @(negedge clk);
        send(OP_ANDI, 3'd1, 3'd0, 3'd1, 3'd1, 16'd1, 16'h0000, 1'b0, acc);
        repeat (6) @(negedge clk);
        send(OP_JMP, 3'd0, 3'd0, 3'd0, 3'd0, 16'd256, 16'h0000, 1'b0, acc);
        repeat (6) @(negedge clk);
        check("err_total", err_hi - eh, 4);
        send(OP_ADDI, 3'd0, 3'd0, 3'd1, 3'd1, 16'hFFE0, 16'h2260, 1'b1, acc);
        drain();
        check("count_after_legal", {23'd0, count}, exp_cnt);
`else
        send(OP_ADDI, 3'd0, 3'd0, 3'd1, 3'd1, 16'd40, 16'h2268, 1'b1, acc);
        drain();
        check("no_err_without_check", err_hi - eh, 0);
        check("count_after_trunc", {23'd0, count}, exp_cnt);
`endif

        // Fill: start at 0xFF, 256 writes, pointer wraps, full rises.
        pulse_restart(8'hFF);
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            send(OP_R, b[2:0], 3'd0, {1'b0, b[7:6]}, b[5:3], 16'h0000, {8'h00, b}, 1'b1, acc);
        end
        drain();
        check("full_set", {31'd0, full}, 32'd1);
        check("count_full", {23'd0, count}, exp_cnt);
        check("ready_full", {31'd0, bus.in_ready}, 32'd0);

        // 257th request must never be accepted.
        ws           = wr_seen;
        rh           = 0;
        bus.in_op    = OP_R;
        bus.in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.in_ready) rh++;
        end
        bus.in_valid = 1'b0;
        check("no_accept_when_full", rh, 0);
        check("no_write_when_full", wr_seen, ws);
        check("count_held_full", {23'd0, count}, 32'd256);

        pulse_restart(8'h00);
        @(negedge clk);
        check("full_cleared", {31'd0, full}, 32'd0);
        check("count_cleared", {23'd0, count}, 32'd0);
        check("ready_restored", {31'd0, bus.in_ready}, 32'd1);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
